// File: rtl/counter_pkg.sv
// Shared encodings for the parametrised up/down counter: mode field values
// and direction constants used by both the datapath and its next-state logic.
package counter_pkg;

  localparam logic [1:0] MODE_SAT    = 2'b00;
  localparam logic [1:0] MODE_WRAP   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-value logic for the counter: applies STEP in the
// selected mode and reports wrap/reversal plus the next bounce direction.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 12,
  parameter int unsigned STEP    = 1
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             dir,
  input  logic             bdir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap,
  output logic             bdir_nxt
);

  // Two extra bits: one for the carry out of up, one for the sign of down.
  localparam int unsigned SW = WIDTH + 2;

  localparam logic signed [SW-1:0] MaxS   = SW'(MAX_VAL);
  localparam logic signed [SW-1:0] MinS   = SW'(MIN_VAL);
  localparam logic signed [SW-1:0] StepS  = SW'(STEP);
  localparam logic signed [SW-1:0] RangeS = SW'(MAX_VAL - MIN_VAL + 1);

  logic signed [SW-1:0] cur_s;
  logic signed [SW-1:0] up_s;
  logic signed [SW-1:0] down_s;

  assign cur_s  = $signed({2'b00, cur});
  assign up_s   = cur_s + StepS;
  assign down_s = cur_s - StepS;

  always_comb begin
    nxt      = cur;
    wrap     = 1'b0;
    bdir_nxt = bdir;
    case (mode)
      MODE_WRAP: begin
        if (dir == DIR_UP) begin
          if (up_s > MaxS) begin
            nxt  = WIDTH'(up_s - RangeS);
            wrap = 1'b1;
          end else begin
            nxt = WIDTH'(up_s);
          end
        end else begin
          if (down_s < MinS) begin
            nxt  = WIDTH'(down_s + RangeS);
            wrap = 1'b1;
          end else begin
            nxt = WIDTH'(down_s);
          end
        end
      end
      MODE_BOUNCE: begin
        // Reaching a bound (or already sitting on it) reverses without a stall cycle.
        if (bdir == DIR_UP) begin
          if (up_s >= MaxS) begin
            nxt      = WIDTH'(MAX_VAL);
            bdir_nxt = DIR_DOWN;
            wrap     = 1'b1;
          end else begin
            nxt = WIDTH'(up_s);
          end
        end else begin
          if (down_s <= MinS) begin
            nxt      = WIDTH'(MIN_VAL);
            bdir_nxt = DIR_UP;
            wrap     = 1'b1;
          end else begin
            nxt = WIDTH'(down_s);
          end
        end
      end
      MODE_SAT, MODE_RSVD: begin
        if (dir == DIR_UP) begin
          nxt = (up_s > MaxS) ? WIDTH'(MAX_VAL) : WIDTH'(up_s);
        end else begin
          nxt = (down_s < MinS) ? WIDTH'(MIN_VAL) : WIDTH'(down_s);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with saturate, wrap and bounce modes, terminal
// flags, a wrap pulse and clamped loads with an out-of-range pulse.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DATA_W  = 6,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 12,
  parameter int unsigned STEP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data,
  output logic [WIDTH-1:0]  out,
  output logic              at_max,
  output logic              at_min,
  output logic              wrapped,
  output logic              load_err
);

  // Load compare width covers both the data bus and the counter range.
  localparam int unsigned CW = (DATA_W > WIDTH) ? DATA_W : WIDTH;

  logic [WIDTH-1:0] out_q, out_d;
  logic             bdir_q, bdir_d;
  logic             wrapped_q, wrapped_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH-1:0] calc_nxt;
  logic             calc_wrap;
  logic             calc_bdir;

  logic [CW-1:0]    data_ext;
  logic             above_max;
  logic             below_min;
  logic [WIDTH-1:0] load_val;

  counter_next_calc #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL),
    .STEP    (STEP)
  ) u_next_calc (
    .cur      (out_q),
    .dir      (dir),
    .bdir     (bdir_q),
    .mode     (mode),
    .nxt      (calc_nxt),
    .wrap     (calc_wrap),
    .bdir_nxt (calc_bdir)
  );

  assign data_ext  = CW'(data);
  assign above_max = data_ext > CW'(MAX_VAL);

  // With a zero lower bound no unsigned value can be below it.
  if (MIN_VAL == 0) begin : g_no_min_check
    assign below_min = 1'b0;
  end else begin : g_min_check
    assign below_min = data_ext < CW'(MIN_VAL);
  end

  always_comb begin
    load_val = data_ext[WIDTH-1:0];
    if (above_max) begin
      load_val = WIDTH'(MAX_VAL);
    end else if (below_min) begin
      load_val = WIDTH'(MIN_VAL);
    end
  end

  always_comb begin
    out_d      = out_q;
    bdir_d     = bdir_q;
    wrapped_d  = 1'b0;
    load_err_d = 1'b0;
    if (en) begin
      if (load) begin
        out_d      = load_val;
        bdir_d     = dir;
        load_err_d = above_max | below_min;
      end else begin
        out_d     = calc_nxt;
        bdir_d    = calc_bdir;
        wrapped_d = calc_wrap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q      <= WIDTH'(MIN_VAL);
      bdir_q     <= DIR_UP;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      bdir_q     <= bdir_d;
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
    end
  end

  assign out      = out_q;
  assign at_max   = (out_q == WIDTH'(MAX_VAL));
  assign at_min   = (out_q == WIDTH'(MIN_VAL));
  assign wrapped  = wrapped_q;
  assign load_err = load_err_q;

endmodule
